// File: rtl/hex_vertex_fetch_if.sv
// Bundles the start command, host read bus and pipeline vertex output of the vertex fetcher.
// Latency: none; wires only.
// Backpressure: host side uses mem_rd_gnt; the pipeline side has none.
interface hex_vertex_fetch_if #(
    parameter int COUNT_W = 16
);
    // command / status
    logic               start;
    logic [31:0]        vtx_base;
    logic [COUNT_W-1:0] vtx_count;
    logic               busy;
    logic               done;
    // host read interface, in-order returns
    logic               mem_rd_req;
    logic [31:0]        mem_rd_addr;
    logic               mem_rd_gnt;
    logic               mem_rd_valid;
    logic [31:0]        mem_rd_data;
    // pipeline vertex input
    logic               frame_start;
    logic               out_valid;
    logic [31:0]        out_x;
    logic [31:0]        out_y;
    logic [31:0]        out_z;

    // fetcher side
    modport master (
        input  start, vtx_base, vtx_count, mem_rd_gnt, mem_rd_valid, mem_rd_data,
        output busy, done, mem_rd_req, mem_rd_addr, frame_start, out_valid, out_x, out_y, out_z
    );

    // host / pipeline side
    modport slave (
        output start, vtx_base, vtx_count, mem_rd_gnt, mem_rd_valid, mem_rd_data,
        input  busy, done, mem_rd_req, mem_rd_addr, frame_start, out_valid, out_x, out_y, out_z
    );
endinterface

// File: rtl/hex_vertex_fetch.sv
// Generic synchronous FIFO used as the read-response buffer.
// Latency: a pushed word is visible on pop_dat the following cycle.
// Backpressure: none internally; the caller never pushes when full unless it also pops.
module hvf_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic [AW:0]   count,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // storage write; contents need no reset since count gates reads
    always_ff @(posedge clk) begin : store
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin : ptrs
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign empty   = (count == '0);
endmodule

// Reads a packed x/y/z vertex buffer from host memory and emits vertices to the pipeline.
// Latency: first request the cycle after frame_start; out_valid one cycle after the z word pops.
// Backpressure: host grant stalls hold address; outstanding+buffered words never exceed FIFO_DEPTH.
module hex_vertex_fetch #(
    parameter int FIFO_DEPTH = 8,
    parameter int COUNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    hex_vertex_fetch_if.master  bus
);
    localparam int WC_W  = COUNT_W + 2;
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W:0] DEPTH_L = (OCC_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FRAME,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       base_q, base_d;
    logic [WC_W-1:0]   total_q;
    logic [WC_W-1:0]   total_in;
    logic [WC_W-1:0]   issued_q, issued_d, issued_inc;
    logic [OCC_W-1:0]  outst_q, outst_d;
    logic [OCC_W-1:0]  occ_d;
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;

    logic              gnt_fire;
    logic              rsp_fire;
    logic              pop;
    logic [31:0]       fifo_dat;
    logic [OCC_W-1:0]  fifo_count;
    logic              fifo_empty;

    logic [1:0]        slot_q;
    logic [31:0]       x_stage_q, y_stage_q;
    logic [31:0]       out_x_q, out_y_q, out_z_q;
    logic              out_valid_q;

    // 3*count without truncation: count + 2*count at full width
    assign total_in   = {2'b00, bus.vtx_count} + {1'b0, bus.vtx_count, 1'b0};
    assign issued_inc = issued_q + 1'b1;
    assign gnt_fire   = req_q && bus.mem_rd_gnt;
    // returns are only meaningful once a fetch is under way
    assign rsp_fire   = bus.mem_rd_valid &&
                        ((state_q == ST_FETCH) || (state_q == ST_DRAIN) || (state_q == ST_DONE));
    assign pop        = (state_q != ST_IDLE) && !fifo_empty;

    hvf_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rsp_fire),
        .push_dat (bus.mem_rd_data),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    // frame sequencing: idle -> frame -> fetch -> drain -> done
    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_FRAME;
            ST_FRAME: state_d = (total_q != '0) ? ST_FETCH : ST_DONE;
            ST_FETCH: if (gnt_fire && (issued_inc == total_q)) state_d = ST_DRAIN;
            ST_DRAIN: if (out_valid_q && (outst_q == '0) && fifo_empty && (slot_q == 2'd0))
                          state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // next request/credit state, evaluated on next-cycle counts so the registered req never overruns the FIFO
    always_comb begin : credit_next
        issued_d = issued_q;
        if (state_q == ST_IDLE) begin
            issued_d = '0;
        end else if (gnt_fire) begin
            issued_d = issued_inc;
        end

        outst_d = outst_q;
        if (gnt_fire && !rsp_fire) begin
            outst_d = outst_q + 1'b1;
        end else if (!gnt_fire && rsp_fire) begin
            outst_d = outst_q - 1'b1;
        end

        occ_d = fifo_count;
        if (rsp_fire && !pop) begin
            occ_d = fifo_count + 1'b1;
        end else if (!rsp_fire && pop) begin
            occ_d = fifo_count - 1'b1;
        end

        base_d = ((state_q == ST_IDLE) && bus.start) ? bus.vtx_base : base_q;
        req_d  = (state_d == ST_FETCH) && (issued_d < total_q) &&
                 (({1'b0, outst_d} + {1'b0, occ_d}) < DEPTH_L);
        // byte address wraps naturally at 32 bits
        addr_d = base_d + (32'(issued_d) << 2);
    end

    // control and request registers
    always_ff @(posedge clk) begin : ctrl_regs
        if (reset) begin
            state_q  <= ST_IDLE;
            base_q   <= '0;
            total_q  <= '0;
            issued_q <= '0;
            outst_q  <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            issued_q <= issued_d;
            outst_q  <= outst_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            if ((state_q == ST_IDLE) && bus.start) begin
                total_q <= total_in;
            end
        end
    end

    // vertex assembly: one word per cycle into x, y, then z; z completes the vertex
    always_ff @(posedge clk) begin : assemble
        if (reset) begin
            slot_q      <= 2'd0;
            x_stage_q   <= '0;
            y_stage_q   <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_z_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= pop && (slot_q == 2'd2);
            if (pop) begin
                case (slot_q)
                    2'd0: begin
                        x_stage_q <= fifo_dat;
                        slot_q    <= 2'd1;
                    end
                    2'd1: begin
                        y_stage_q <= fifo_dat;
                        slot_q    <= 2'd2;
                    end
                    2'd2: begin
                        out_x_q <= x_stage_q;
                        out_y_q <= y_stage_q;
                        out_z_q <= fifo_dat;
                        slot_q  <= 2'd0;
                    end
                    default: slot_q <= 2'd0;
                endcase
            end
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.frame_start = (state_q == ST_FRAME);
    assign bus.mem_rd_req  = req_q;
    assign bus.mem_rd_addr = addr_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_x       = out_x_q;
    assign bus.out_y       = out_y_q;
    assign bus.out_z       = out_z_q;
endmodule

// File: tb/tb_hex_vertex_fetch.sv
// Scoreboard bench for hex_vertex_fetch: randomized host memory model and vertex reference.
// Latency: memory model returns in order after a per-run latency.
// Backpressure: grant is driven with a per-run probability.
module tb_hex_vertex_fetch;
    logic clk;
    logic reset;

    hex_vertex_fetch_if #(.COUNT_W(16)) bus ();

    hex_vertex_fetch #(
        .FIFO_DEPTH (8),
        .COUNT_W    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // scoreboard queues filled at stimulus time
    logic [31:0] exp_addr [$];
    logic [95:0] exp_vtx  [$];
    int          exp_cnt  [$];

    // memory model configuration, set per run
    logic [31:0] key      = 32'h0;
    int          gnt_pct  = 100;
    int          lat      = 2;
    int          junk     = 0;
    int          resp_cnt = 0;
    int          dcyc     = 0;
    int          pend_due [$];
    logic [31:0] pend_dat [$];

    // monitor state
    int   mcyc        = 0;
    int   frame_cyc   = 0;
    int   last_ov     = 0;
    int   nv          = 0;
    int   grants_run  = 0;
    int   req_cyc_run = 0;
    int   frames      = 0;
    int   done_cnt    = 0;
    int   launches    = 0;
    bit   credit_mode = 0;
    bit   first_rsp   = 0;
    logic prev_req    = 0;
    logic prev_gnt    = 0;
    logic [31:0] prev_addr = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // host memory: word at address A reads A ^ key, returned in order after lat cycles
    initial begin
        bus.mem_rd_gnt   = 1'b0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            dcyc++;
            if (reset) begin
                pend_due.delete();
                pend_dat.delete();
            end
            if (junk > 0) begin
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data  = $urandom;
                junk--;
            end else if (pend_due.size() > 0 && pend_due[0] <= dcyc) begin
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data  = pend_dat.pop_front();
                void'(pend_due.pop_front());
                resp_cnt++;
            end else begin
                bus.mem_rd_valid = 1'b0;
            end
            bus.mem_rd_gnt = ($urandom_range(99) < gnt_pct);
            if (bus.mem_rd_req && bus.mem_rd_gnt) begin
                pend_due.push_back(dcyc + lat);
                pend_dat.push_back(bus.mem_rd_addr ^ key);
            end
        end
    end

    // monitor: compares every grant, vertex and done against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            mcyc++;
            if (reset) begin
                prev_req = 1'b0;
                prev_gnt = 1'b0;
            end else begin
                if (bus.frame_start) begin
                    frame_cyc   = mcyc;
                    grants_run  = 0;
                    req_cyc_run = 0;
                    nv          = 0;
                    first_rsp   = 0;
                    frames++;
                end
                if (credit_mode && !first_rsp && bus.mem_rd_valid && bus.busy) begin
                    first_rsp = 1;
                    chk("credit_grants_before_rsp", 96'(grants_run), 96'd8);
                end
                if (prev_req && !prev_gnt) begin
                    chk("stall_hold", {63'd0, bus.mem_rd_req, bus.mem_rd_addr}, {63'd0, 1'b1, prev_addr});
                end
                if (bus.mem_rd_req) req_cyc_run++;
                if (bus.mem_rd_req && bus.mem_rd_gnt) begin
                    grants_run++;
                    if (exp_addr.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_grant: addr %h with nothing expected", bus.mem_rd_addr);
                    end else begin
                        chk("rd_addr", 96'(bus.mem_rd_addr), 96'(exp_addr.pop_front()));
                    end
                end
                if (bus.out_valid) begin
                    if (exp_vtx.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_vertex: got %h %h %h", bus.out_x, bus.out_y, bus.out_z);
                    end else begin
                        chk("vertex", {bus.out_x, bus.out_y, bus.out_z}, exp_vtx.pop_front());
                    end
                    chk("frame_gap", 96'(mcyc - frame_cyc >= 2), 96'd1);
                    last_ov = mcyc;
                    nv++;
                end
                if (bus.done) begin
                    done_cnt++;
                    if (exp_cnt.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_done: done with no run pending");
                    end else begin
                        int c;
                        c = exp_cnt.pop_front();
                        chk("vertex_count", 96'(nv), 96'(c));
                        chk("grant_count", 96'(grants_run), 96'(3 * c));
                        chk("done_timing", 96'(mcyc), 96'(((c == 0) ? frame_cyc : last_ov) + 1));
                        if (c == 0) chk("zero_no_req", 96'(req_cyc_run), 96'd0);
                    end
                end
                prev_req  = bus.mem_rd_req;
                prev_gnt  = bus.mem_rd_gnt;
                prev_addr = bus.mem_rd_addr;
            end
        end
    end

    // issue a start and record what the reference expects from it
    task automatic launch(input logic [31:0] b, input int n, input logic [31:0] k,
                          input int gp, input int l);
        @(posedge clk);
        #2;
        key     = k;
        gnt_pct = gp;
        lat     = l;
        for (int i = 0; i < 3 * n; i++) exp_addr.push_back(b + 32'(4 * i));
        for (int v = 0; v < n; v++) begin
            logic [31:0] a;
            a = b + 32'(12 * v);
            exp_vtx.push_back({a ^ k, (a + 32'd4) ^ k, (a + 32'd8) ^ k});
        end
        exp_cnt.push_back(n);
        launches++;
        bus.vtx_base  = b;
        bus.vtx_count = 16'(n);
        bus.start     = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int tgt);
        int t;
        t = 0;
        while (done_cnt < tgt && t < 3000) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("done_reached", 96'(done_cnt >= tgt), 96'd1);
    endtask

    initial begin
        int d0;
        int r0;
        int t;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.vtx_base  = 32'h0;
        bus.vtx_count = 16'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {91'd0, bus.busy, bus.done, bus.mem_rd_req, bus.frame_start, bus.out_valid}, 96'd0);
        chk("rst_addr", 96'(bus.mem_rd_addr), 96'd0);
        chk("rst_xyz", {bus.out_x, bus.out_y, bus.out_z}, 96'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // basic: word at A reads A
        d0 = done_cnt;
        launch(32'h0000_1000, 2, 32'h0, 100, 2);
        wait_done(d0 + 1);

        // credit limit: long latency, exactly FIFO_DEPTH grants before the first return
        credit_mode = 1;
        d0 = done_cnt;
        launch(32'h0000_2000, 4, 32'h0, 100, 20);
        wait_done(d0 + 1);
        credit_mode = 0;

        // random grant stalls
        d0 = done_cnt;
        launch(32'h0001_0040, 5, $urandom, 50, 3);
        wait_done(d0 + 1);

        // zero count
        d0 = done_cnt;
        launch(32'h0000_5000, 0, 32'h0, 100, 2);
        wait_done(d0 + 1);

        // start while busy is ignored
        d0 = done_cnt;
        launch(32'h0000_6000, 3, $urandom, 70, 4);
        repeat (3) @(posedge clk);
        #2;
        bus.vtx_base  = 32'h0000_9000;
        bus.vtx_count = 16'd7;
        bus.start     = 1'b1;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        wait_done(d0 + 1);

        // address wrap
        d0 = done_cnt;
        launch(32'hFFFF_FFF8, 1, 32'h0, 100, 2);
        wait_done(d0 + 1);

        // reset after 5 of 9 words returned, then late returns while idle
        r0 = resp_cnt;
        launch(32'h0000_3000, 3, $urandom, 100, 3);
        t = 0;
        while (resp_cnt < r0 + 5 && t < 500) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("reset_point_reached", 96'(resp_cnt >= r0 + 5), 96'd1);
        reset = 1'b1;
        junk  = 4;
        exp_addr.delete();
        exp_vtx.delete();
        exp_cnt.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {92'd0, bus.busy, bus.done, bus.mem_rd_req, bus.out_valid}, 96'd0);
        end
        chk("post_rst_xyz", {bus.out_x, bus.out_y, bus.out_z}, 96'd0);
        d0 = done_cnt;
        launch(32'h0000_4000, 1, 32'h0, 100, 2);
        wait_done(d0 + 1);

        // randomized runs
        for (int r = 0; r < 10; r++) begin
            logic [31:0] b;
            b = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 + 32'(4 * $urandom_range(7)))
                                         : ($urandom & 32'hFFFF_FFFC);
            d0 = done_cnt;
            launch(b, $urandom_range(1, 6), $urandom, $urandom_range(30, 100), $urandom_range(1, 8));
            wait_done(d0 + 1);
        end

        repeat (5) @(posedge clk);
        #2;
        chk("frame_count", 96'(frames), 96'(launches));
        chk("scoreboard_empty", 96'(exp_addr.size() + exp_vtx.size() + exp_cnt.size()), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
